keypad_scan_ctrl: RTL and testbench

//  Drives and scans the 4x4 matrix keypad, debounces it and emits one key event per press.

---
 rtl/keypad_pkg.sv | 61 ++++++
 rtl/keypad_scan_ctrl_sync_2ff.sv | 23 ++
 rtl/keypad_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, special key codes,
// and decoders from the active-low row/column patterns to key codes.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    HOLD,
    RELEASE
  } kp_state_t;

  localparam logic [3:0] KEY_STAR  = 4'hD;
  localparam logic [3:0] KEY_HASH  = 4'hE;
  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] ROWS_IDLE = 4'hF;
  localparam logic [3:0] COL_FIRST = 4'b1110;

  // The 'D' key position returns KEY_NONE so it is debounced but never reported.
  function automatic logic [3:0] kp_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = KEY_NONE;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Index of the low bit in a pattern with a single zero.
  function automatic logic [1:0] low_idx(input logic [3:0] pat);
    logic [1:0] idx;
    idx = 2'd0;
    case (pat)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic one_low(input logic [3:0] pat);
    return (pat == 4'b1110) || (pat == 4'b1101) || (pat == 4'b1011) || (pat == 4'b0111);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync_2ff.sv
// Two-flop synchronizer for the raw keypad rows; resets to all-ones (rows idle, pulled up).
module sync_2ff #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with debounce and one key_valid strobe per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key is held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES  = 27_000,
  parameter int unsigned DEB_CYCLES   = 540_000
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY = 13_500_000,
  parameter int unsigned REPEAT_RATE  = 5_400_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEB_CYCLES) ? SCAN_CYCLES : DEB_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  kp_state_t        state_q, state_d;
  logic [3:0]       row_s;
  logic [3:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_lat_q, row_lat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       map_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_en_q, rep_en_d;
`endif

  sync_2ff #(.W(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (fil_i),
    .q   (row_s)
  );

  assign map_code  = kp_map(low_idx(row_lat_q), low_idx(col_q));
  assign col_o     = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      col_q       <= COL_FIRST;
      cnt_q       <= '0;
      row_lat_q   <= ROWS_IDLE;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      rep_en_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      row_lat_q   <= row_lat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      rep_en_q    <= rep_en_d;
`endif
    end
  end

  // Next-state and next-output logic; key_valid is set on the edge into PRESSED.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    row_lat_d   = row_lat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_en_d    = rep_en_q;
`endif

    case (state_q)
      SCAN: begin
        if (row_s != ROWS_IDLE) begin
          state_d   = DEBOUNCE;
          cnt_d     = '0;
          row_lat_d = row_s;
        end else if (cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          col_d = {col_q[2:0], col_q[3]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DEBOUNCE: begin
        if (row_s != row_lat_q) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = {col_q[2:0], col_q[3]};
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          cnt_d = '0;
          if (one_low(row_lat_q)) begin
            state_d    = PRESSED;
            key_held_d = 1'b1;
            if (map_code != KEY_NONE) begin
              key_code_d  = map_code;
              key_valid_d = 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
            rep_en_d    = (map_code != KEY_NONE) && (map_code != KEY_STAR) &&
                          (map_code != KEY_HASH);
`endif
          end else begin
            // Ghosting or multi-key: wait for a clean release without reporting.
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
      end

      HOLD: begin
        if (row_s == ROWS_IDLE) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_en_q) begin
          if (rep_cnt_q == (rep_first_q ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_RATE - 1))) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
`endif
      end

      RELEASE: begin
        if (row_s != ROWS_IDLE) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          state_d    = SCAN;
          cnt_d      = '0;
          col_d      = COL_FIRST;
          key_held_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
        col_d   = COL_FIRST;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 matrix driven by col_o.
// Repeat checks are compiled in when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fil_i;
  logic [3:0] col_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;     // bit r*4+c = key at (row r, col c) pressed

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pulses = 0;
  logic       prev_valid = 1'b0;
  logic       dbl = 1'b0;
  logic [3:0] last_code = 4'hF;
  int         pq[$];

  keypad_scan_ctrl #(
    .SCAN_CYCLES  (4),
    .DEB_CYCLES   (8)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY (40),
    .REPEAT_RATE  (16)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fil_i     (fil_i),
    .col_o     (col_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    fil_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) fil_i[r] = 1'b0;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid === 1'b1) begin
        if (prev_valid) dbl = 1'b1;
        pulses++;
        last_code = key_code;
        pq.push_back(cyc);
      end
      prev_valid = key_valid;
    end
  endtask

  task automatic clear_stats();
    pulses = 0;
    dbl    = 1'b0;
    pq.delete();
  endtask

  task automatic wait_pulse(input int budget);
    for (int i = 0; i < budget && pulses == 0; i++) step(1);
  endtask

  task automatic release_all();
    keys = '0;
    step(30);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    keys = '0;
    step(3);
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", col_o); end
    checks++; if (key_code !== 4'hF) begin errors++; $display("FAIL reset_code: got %h expected f", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
    rst = 1'b1;
  endtask

  task automatic test_rotation();
    step(3);
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL rot_c0: got %b expected 1110", col_o); end
    step(1);
    checks++; if (col_o !== 4'b1101) begin errors++; $display("FAIL rot_c1: got %b expected 1101", col_o); end
    step(4);
    checks++; if (col_o !== 4'b1011) begin errors++; $display("FAIL rot_c2: got %b expected 1011", col_o); end
    step(4);
    checks++; if (col_o !== 4'b0111) begin errors++; $display("FAIL rot_c3: got %b expected 0111", col_o); end
    step(4);
    checks++; if (col_o !== 4'b1110) begin errors++; $display("FAIL rot_wrap: got %b expected 1110", col_o); end
  endtask

  // Column 0 just started with counter 0: col1 drives 4 edges later, pulse 2+8+1 after that.
  task automatic test_press_5();
    clear_stats();
    keys[5] = 1'b1;
    step(14);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL p5_early: got %0d pulses expected 0", pulses); end
    step(1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL p5_latency: got valid %b expected 1", key_valid); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL p5_code: got %h expected 5", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL p5_held: got %b expected 1", key_held); end
    step(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL p5_strobe: got valid %b expected 0", key_valid); end
    step(28);
    checks++; if (pulses !== 1 || dbl !== 1'b0) begin errors++; $display("FAIL p5_count: got %0d pulses dbl=%b expected 1 dbl=0", pulses, dbl); end
    keys = '0;
    step(10);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL p5_held_release: got %b expected 1", key_held); end
    step(1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL p5_unheld: got %b expected 0", key_held); end
    step(10);
  endtask

  task automatic test_bounce_7();
    clear_stats();
    for (int i = 0; i < 7; i++) begin
      keys[8] = (i % 2 == 0);
      step(3);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL b7_during_bounce: got %0d pulses expected 0", pulses); end
    keys[8] = 1'b1;
    wait_pulse(60);
    step(20);
    checks++; if (pulses !== 1 || last_code !== 4'h7) begin errors++; $display("FAIL b7_event: got %0d pulses code %h expected 1 code 7", pulses, last_code); end
    release_all();
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL b7_release: got held %b expected 0", key_held); end
  endtask

  task automatic test_star_hash_d();
    clear_stats();
    keys[12] = 1'b1;
    wait_pulse(60);
    step(20);
    checks++; if (pulses !== 1 || last_code !== 4'hD) begin errors++; $display("FAIL star: got %0d pulses code %h expected 1 code d", pulses, last_code); end
    release_all();
    clear_stats();
    keys[14] = 1'b1;
    wait_pulse(60);
    step(20);
    checks++; if (pulses !== 1 || last_code !== 4'hE) begin errors++; $display("FAIL hash: got %0d pulses code %h expected 1 code e", pulses, last_code); end
    release_all();
    clear_stats();
    keys[15] = 1'b1;
    wait_pulse(60);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL dkey_pulse: got %0d pulses expected 0", pulses); end
    checks++; if (key_code !== 4'hE) begin errors++; $display("FAIL dkey_code: got %h expected e", key_code); end
    release_all();
  endtask

  task automatic test_multi_key();
    clear_stats();
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    wait_pulse(60);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL multi_pulse: got %0d pulses expected 0", pulses); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b expected 0", key_held); end
    release_all();
    clear_stats();
    keys[1] = 1'b1;
    wait_pulse(60);
    step(20);
    checks++; if (pulses !== 1 || last_code !== 4'h2) begin errors++; $display("FAIL after_multi: got %0d pulses code %h expected 1 code 2", pulses, last_code); end
    release_all();
  endtask

  task automatic test_reset_mid_press();
    clear_stats();
    keys[5] = 1'b1;
    wait_pulse(60);
    step(5);
    rst = 1'b0;
    step(2);
    checks++; if (key_held !== 1'b0 || key_code !== 4'hF || col_o !== 4'b1110) begin
      errors++; $display("FAIL midreset: got held %b code %h col %b expected 0 f 1110", key_held, key_code, col_o);
    end
    rst = 1'b1;
    clear_stats();
    wait_pulse(60);
    step(20);
    checks++; if (pulses !== 1 || last_code !== 4'h5) begin errors++; $display("FAIL repress: got %0d pulses code %h expected 1 code 5", pulses, last_code); end
    release_all();
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int exp_off[5] = '{0, 40, 56, 72, 88};
    int a;
    clear_stats();
    keys[2] = 1'b1;
    wait_pulse(60);
    a = (pq.size() > 0) ? pq[0] : 0;
    step(99);
    checks++; if (pq.size() !== 5 || dbl !== 1'b0) begin errors++; $display("FAIL rep_count: got %0d pulses dbl=%b expected 5", pq.size(), dbl); end
    if (pq.size() == 5) begin
      for (int i = 1; i < 5; i++) begin
        checks++; if (pq[i] - a !== exp_off[i]) begin errors++; $display("FAIL rep_offset%0d: got %0d expected %0d", i, pq[i] - a, exp_off[i]); end
      end
    end
    checks++; if (last_code !== 4'h3) begin errors++; $display("FAIL rep_code: got %h expected 3", last_code); end
    release_all();
    clear_stats();
    keys[14] = 1'b1;
    wait_pulse(60);
    step(150);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hash_norepeat: got %0d pulses expected 1", pulses); end
    release_all();
  endtask
`endif

  initial begin
    rst  = 1'b0;
    keys = '0;
    test_reset();
    test_rotation();
    test_press_5();
    test_bounce_7();
    test_star_hash_d();
    test_multi_key();
    test_reset_mid_press();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
